// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel stream blocks: lane geometry, output
// frame size and the 8-bit magnitude saturation.
package sobel_pkg;

  localparam int PIX_W = 8;
  localparam int LANES = 4;

  // Kept pixels per frame for the default 32x32 image.
  localparam int OUT_PIX = (32 - 2) * (32 - 2);

  // Kept pixels per frame for an arbitrary image size.
  function automatic int out_pix(input int w, input int h);
    return (w - 2) * (h - 2);
  endfunction

  // Clamp an unsigned 32-bit magnitude to 8 bits.
  function automatic logic [PIX_W-1:0] sat8(input logic [31:0] v);
    return (|v[31:PIX_W]) ? {PIX_W{1'b1}} : v[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry registered stream buffer (main output register plus one skid
// register). in_ready comes straight from a flop, so there is no
// combinational path from out_ready back to the producer.
module stream_skid_buf #(
  parameter int W = 34
) (
  input  logic         aclk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         push;

  // A free entry exists whenever the skid register is empty; a push that
  // coincides with a pop of a full main register lands in main directly.
  assign in_ready = ~skid_valid;
  assign push     = in_valid & in_ready;

  // Main register refills from skid first (oldest data), then from input.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      if (!out_valid || out_ready) begin
        if (skid_valid) begin
          out_data   <= skid_data;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end else if (push) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (push) begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sobel_stream_packer.sv
// Sink-side packer for the Sobel core: drops the two warm-up rows and
// columns, saturates magnitudes to 8 bits, packs four pixels per word and
// tags first/last words of each output frame.
module sobel_stream_packer
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_user,
  output logic                  m_last,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  frame_cnt
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

  logic [1:0]            sync_q;
  logic                  rst_n;
  logic                  run_q;

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [1:0]            lane;
  logic [DATA_WIDTH-1:0] pack;
  logic                  first_q;

  logic                  pend_valid;
  logic                  pend_user;
  logic                  pend_last;
  logic [DATA_WIDTH-1:0] pend_data;

  logic                  buf_ready;
  logic [DATA_WIDTH+1:0] buf_out;

  logic                  acc;
  logic                  keep;
  logic                  end_col;
  logic                  end_frame;
  logic                  word_done;
  logic [PIX_W-1:0]      pix;
  logic [DATA_WIDTH-1:0] word;

  // Reset asserts asynchronously and releases two edges after aresetn rises.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], 1'b1};
  end

  assign rst_n = sync_q[1];

  // Holds s_ready low until the first edge after reset release.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // Only register outputs feed s_ready: a completed word can always move
  // into the pending slot because the slot is empty or draining this cycle.
  assign s_ready   = run_q & (~pend_valid | buf_ready);
  assign acc       = s_valid & s_ready;
  assign end_col   = (col == COL_MAX);
  assign end_frame = end_col && (row == ROW_MAX);
  assign keep      = (row >= RW'(2)) && (col >= CW'(2));
  assign pix       = sat8(s_data);
  assign word_done = acc & keep & ((lane == 2'(LANES - 1)) | end_frame);

  // Insert the incoming pixel into its lane of the partial word.
  always_comb begin
    word = pack;
    word[int'(lane) * PIX_W +: PIX_W] = pix;
  end

  // Column/row position of the next beat; advances on every accepted beat.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (end_col) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Pack register and lane pointer; cleared after each pushed word so the
  // unused lanes of a final partial word read as zero.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      pack    <= '0;
      lane    <= '0;
      first_q <= 1'b1;
    end else if (acc && keep) begin
      if (word_done) begin
        pack    <= '0;
        lane    <= '0;
        first_q <= end_frame;
      end else begin
        pack <= word;
        lane <= lane + 2'd1;
      end
    end
  end

  // One-word pending slot between the packer and the output buffer.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_user  <= 1'b0;
      pend_last  <= 1'b0;
      pend_data  <= '0;
    end else if (word_done) begin
      pend_valid <= 1'b1;
      pend_user  <= first_q;
      pend_last  <= end_frame;
      pend_data  <= word;
    end else if (pend_valid && buf_ready) begin
      pend_valid <= 1'b0;
    end
  end

  stream_skid_buf #(
    .W(DATA_WIDTH + 2)
  ) u_buf (
    .aclk      (aclk),
    .rst_n     (rst_n),
    .in_valid  (pend_valid),
    .in_ready  (buf_ready),
    .in_data   ({pend_last, pend_user, pend_data}),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (buf_out)
  );

  assign {m_last, m_user, m_data} = buf_out;

  // Frame completion pulse and wrapping frame counter.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= m_valid & m_ready & m_last;
      if (m_valid && m_ready && m_last) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_sobel_stream_packer.sv
// Randomised bench for sobel_stream_packer: a 32x32 instance and a 5x5
// instance share one driver/monitor loop; expected words come from a
// row/column walk of the stimulus with byte packing.
module tb_sobel_stream_packer;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic aresetn;

  logic        a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_m_user, a_m_last, a_frame_done;
  logic [31:0] a_s_data, a_m_data;
  logic [15:0] a_frame_cnt;
  logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_m_user, b_m_last, b_frame_done;
  logic [31:0] b_s_data, b_m_data;
  logic [15:0] b_frame_cnt;

  sobel_stream_packer #(.DATA_WIDTH(32), .IMG_WIDTH(32), .IMG_HEIGHT(32), .CNT_WIDTH(16)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_user(a_m_user),
    .m_last(a_m_last), .frame_done(a_frame_done), .frame_cnt(a_frame_cnt));

  sobel_stream_packer #(.DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(5), .CNT_WIDTH(16)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_user(b_m_user),
    .m_last(b_m_last), .frame_done(b_frame_done), .frame_cnt(b_frame_cnt));

  int          sel = 0;
  logic        drv_valid = 1'b0, drv_ready = 1'b1;
  logic [31:0] drv_data = '0;

  assign a_s_valid = (sel == 0) & drv_valid;
  assign b_s_valid = (sel == 1) & drv_valid;
  assign a_s_data  = drv_data;
  assign b_s_data  = drv_data;
  assign a_m_ready = (sel == 0) ? drv_ready : 1'b1;
  assign b_m_ready = (sel == 1) ? drv_ready : 1'b1;

  logic        o_s_ready, o_m_valid, o_m_user, o_m_last, o_frame_done;
  logic [31:0] o_m_data;
  logic [15:0] o_frame_cnt;
  assign o_s_ready    = (sel == 1) ? b_s_ready    : a_s_ready;
  assign o_m_valid    = (sel == 1) ? b_m_valid    : a_m_valid;
  assign o_m_data     = (sel == 1) ? b_m_data     : a_m_data;
  assign o_m_user     = (sel == 1) ? b_m_user     : a_m_user;
  assign o_m_last     = (sel == 1) ? b_m_last     : a_m_last;
  assign o_frame_done = (sel == 1) ? b_frame_done : a_frame_done;
  assign o_frame_cnt  = (sel == 1) ? b_frame_cnt  : a_frame_cnt;

  int tests = 0;
  int fails = 0;

  logic [31:0] stim_q[$];
  logic [31:0] got_data[$], exp_data[$];
  logic        got_user[$], got_last[$], exp_user[$], exp_last[$];
  int          n_done, n_unstable, n_stall, first_valid_iter, acc_kth_iter, kth_beat;
  bit          timed_out;
  logic        rst_mvalid;

  task automatic apply_reset();
    aresetn   = 1'b0;
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (5) @(posedge aclk);
    #1;
  endtask

  // Append nfr frames of w x h beats; mode 0 = col+row*w, mode 1 = random mix.
  task automatic gen_frames(input int mode, input int w, input int h, input int nfr);
    logic [31:0] v;
    for (int f = 0; f < nfr; f++)
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++) begin
          if (mode == 0) v = 32'(c + r * w);
          else begin
            case ($urandom_range(0, 5))
              0:       v = 32'h0000_0100;
              1:       v = 32'h8000_0000;
              2:       v = 32'd255;
              3:       v = 32'd7;
              4:       v = 32'($urandom_range(0, 255));
              default: v = $urandom;
            endcase
          end
          stim_q.push_back(v);
        end
  endtask

  // Reference: walk each frame, keep pixels outside the warm-up border,
  // clamp, and pack four bytes per word earliest-first.
  task automatic exp_frames(input int w, input int h, input int start, input int nfr);
    logic [7:0]  bytes[$];
    logic [31:0] v, wd;
    for (int f = 0; f < nfr; f++) begin
      bytes.delete();
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++) begin
          v = stim_q[start + f * w * h + r * w + c];
          if (r >= 2 && c >= 2) bytes.push_back((v > 255) ? 8'hFF : v[7:0]);
        end
      for (int i = 0; i < bytes.size(); i += 4) begin
        wd = '0;
        for (int k = 0; k < 4; k++)
          if (i + k < bytes.size()) wd = wd | (32'(bytes[i + k]) << (8 * k));
        exp_data.push_back(wd);
        exp_user.push_back(i == 0);
        exp_last.push_back(i + 4 >= bytes.size());
      end
    end
  endtask

  task automatic count_diff(output int n, output int first);
    n = 0;
    first = -1;
    if (got_data.size() != exp_data.size()) n++;
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
      if (got_data[i] !== exp_data[i] || got_user[i] !== exp_user[i] || got_last[i] !== exp_last[i]) begin
        n++;
        if (first < 0) first = i;
      end
  endtask

  // Drive stim_q, record transfers at the negedge before each active edge.
  task automatic run_stream(input int ready_pct, input int rst_beat, input int jump_to);
    int         idx, iter, budget, quiet;
    bit         holding;
    logic [33:0] hold;
    idx = 0; iter = 0; quiet = 0; holding = 0; hold = '0;
    got_data.delete(); got_user.delete(); got_last.delete();
    n_done = 0; n_unstable = 0; n_stall = 0; timed_out = 0;
    first_valid_iter = -1; acc_kth_iter = -1; rst_mvalid = 1'b1;
    budget = stim_q.size() * 10 + 2000;
    drv_valid = (stim_q.size() > 0);
    drv_data  = stim_q[0];
    drv_ready = ($urandom_range(0, 99) < ready_pct);
    while (1) begin
      @(negedge aclk);
      if (o_m_valid && first_valid_iter < 0) first_valid_iter = iter;
      if (holding && (!o_m_valid || {o_m_last, o_m_user, o_m_data} !== hold)) n_unstable++;
      holding = o_m_valid && !drv_ready;
      hold    = {o_m_last, o_m_user, o_m_data};
      if (o_m_valid && drv_ready) begin
        got_data.push_back(o_m_data);
        got_user.push_back(o_m_user);
        got_last.push_back(o_m_last);
      end
      if (o_frame_done) n_done++;
      if (drv_valid && !o_s_ready) n_stall++;
      if (drv_valid && o_s_ready) begin
        if (idx == kth_beat) acc_kth_iter = iter;
        idx++;
      end
      iter++;
      if (idx >= stim_q.size()) quiet++;
      if (quiet >= 64) break;
      if (iter > budget) begin
        timed_out = 1;
        break;
      end
      @(posedge aclk);
      #1;
      if (rst_beat >= 0 && idx == rst_beat) begin
        aresetn = 1'b0;
        #1 rst_mvalid = o_m_valid;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        idx = jump_to;
        rst_beat = -1;
        holding = 0;
        got_data.delete(); got_user.delete(); got_last.delete();
        n_done = 0;
      end
      drv_valid = (idx < stim_q.size());
      if (idx < stim_q.size()) drv_data = stim_q[idx];
      drv_ready = ($urandom_range(0, 99) < ready_pct);
    end
    drv_valid = 1'b0;
    drv_ready = 1'b1;
  endtask

  task automatic test_reset();
    sel = 0;
    aresetn = 1'b0;
    drv_valid = 1'b1;
    drv_data = 32'h12;
    repeat (2) @(posedge aclk);
    #1;
    tests++; if (a_s_ready !== 1'b0)  begin fails++; $display("FAIL reset_s_ready: got %b want 0", a_s_ready); end
    tests++; if (a_m_valid !== 1'b0)  begin fails++; $display("FAIL reset_m_valid: got %b want 0", a_m_valid); end
    tests++; if (a_m_data !== 32'h0)  begin fails++; $display("FAIL reset_m_data: got %h want 0", a_m_data); end
    tests++; if (a_m_user !== 1'b0 || a_m_last !== 1'b0)
      begin fails++; $display("FAIL reset_user_last: got %b%b want 00", a_m_user, a_m_last); end
    tests++; if (a_frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b want 0", a_frame_done); end
    tests++; if (a_frame_cnt !== 16'h0) begin fails++; $display("FAIL reset_frame_cnt: got %0d want 0", a_frame_cnt); end
    drv_valid = 1'b0;
    #1 aresetn = 1'b1;
    repeat (5) @(posedge aclk);
    #1;
    tests++; if (a_s_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b want 1", a_s_ready); end
  endtask

  task automatic test_full_frame();
    int n, first;
    logic [31:0] w0;
    sel = 0; apply_reset();
    stim_q.delete(); exp_data.delete(); exp_user.delete(); exp_last.delete();
    gen_frames(0, 32, 32, 1); exp_frames(32, 32, 0, 1);
    kth_beat = 2 * 32 + 2 + 3;
    run_stream(100, -1, 0);
    count_diff(n, first);
    tests++; if (timed_out) begin fails++; $display("FAIL t1_timeout: got timeout want completion"); end
    tests++; if (got_data.size() != 225) begin fails++; $display("FAIL t1_words: got %0d want 225", got_data.size()); end
    tests++; if (n != 0) begin fails++; $display("FAIL t1_data: got %0d bad words (first %0d) want 0", n, first); end
    if (got_data.size() >= 225) begin
      w0 = got_data[0];
      tests++; if (w0 !== 32'h4544_4342) begin fails++; $display("FAIL t1_word0: got %h want 45444342", w0); end
      tests++; if (got_user[0] !== 1'b1) begin fails++; $display("FAIL t1_user0: got %b want 1", got_user[0]); end
      tests++; if (got_last[224] !== 1'b1) begin fails++; $display("FAIL t1_last224: got %b want 1", got_last[224]); end
    end
    tests++; if (first_valid_iter - acc_kth_iter != 2)
      begin fails++; $display("FAIL t1_latency: got %0d cycles want 2", first_valid_iter - acc_kth_iter); end
    tests++; if (n_stall != 0) begin fails++; $display("FAIL t1_input_stall: got %0d want 0", n_stall); end
    tests++; if (a_frame_cnt !== 16'd1) begin fails++; $display("FAIL t1_frame_cnt: got %0d want 1", a_frame_cnt); end
  endtask

  task automatic test_saturation();
    int n, first;
    logic [31:0] w0;
    sel = 0; apply_reset();
    stim_q.delete(); exp_data.delete(); exp_user.delete(); exp_last.delete();
    gen_frames(1, 32, 32, 1);
    stim_q[66] = 32'h0000_0100;
    stim_q[67] = 32'h8000_0000;
    stim_q[68] = 32'd255;
    stim_q[69] = 32'd7;
    exp_frames(32, 32, 0, 1);
    kth_beat = -1;
    run_stream(100, -1, 0);
    count_diff(n, first);
    tests++; if (n != 0 || timed_out) begin fails++; $display("FAIL t2_data: got %0d bad words (first %0d) want 0", n, first); end
    if (got_data.size() > 0) begin
      w0 = got_data[0];
      tests++; if (w0 !== 32'h07FF_FFFF) begin fails++; $display("FAIL t2_word0: got %h want 07ffffff", w0); end
    end
  endtask

  task automatic test_small_frame();
    int n, first;
    logic [31:0] wl, last_in;
    logic [7:0]  p8;
    sel = 1; apply_reset();
    stim_q.delete(); exp_data.delete(); exp_user.delete(); exp_last.delete();
    gen_frames(1, 5, 5, 1); exp_frames(5, 5, 0, 1);
    kth_beat = -1;
    run_stream(100, -1, 0);
    count_diff(n, first);
    last_in = stim_q[24];
    p8 = (last_in > 255) ? 8'hFF : last_in[7:0];
    tests++; if (got_data.size() != 3 || timed_out) begin fails++; $display("FAIL t3_words: got %0d want 3", got_data.size()); end
    tests++; if (n != 0) begin fails++; $display("FAIL t3_data: got %0d bad words (first %0d) want 0", n, first); end
    if (got_data.size() == 3) begin
      wl = got_data[2];
      tests++; if (wl !== {24'h0, p8}) begin fails++; $display("FAIL t3_last_word: got %h want %h", wl, {24'h0, p8}); end
      tests++; if (got_last[2] !== 1'b1 || got_last[1] !== 1'b0)
        begin fails++; $display("FAIL t3_last_flags: got %b%b want 10", got_last[2], got_last[1]); end
    end
    tests++; if (b_frame_cnt !== 16'd1) begin fails++; $display("FAIL t3_frame_cnt: got %0d want 1", b_frame_cnt); end
    sel = 0;
  endtask

  task automatic test_backpressure();
    int n, first;
    sel = 0; apply_reset();
    stim_q.delete(); exp_data.delete(); exp_user.delete(); exp_last.delete();
    gen_frames(0, 32, 32, 3); exp_frames(32, 32, 0, 3);
    kth_beat = -1;
    run_stream(50, -1, 0);
    count_diff(n, first);
    tests++; if (timed_out) begin fails++; $display("FAIL t4_timeout: got timeout want completion"); end
    tests++; if (got_data.size() != 675) begin fails++; $display("FAIL t4_words: got %0d want 675", got_data.size()); end
    tests++; if (n != 0) begin fails++; $display("FAIL t4_data: got %0d bad words (first %0d) want 0", n, first); end
    tests++; if (n_unstable != 0) begin fails++; $display("FAIL t4_stable: got %0d changes while stalled want 0", n_unstable); end
    tests++; if (n_done != 3) begin fails++; $display("FAIL t4_frame_done: got %0d pulses want 3", n_done); end
    tests++; if (a_frame_cnt !== 16'd3) begin fails++; $display("FAIL t4_frame_cnt: got %0d want 3", a_frame_cnt); end
  endtask

  task automatic test_reset_midframe();
    int n, first;
    sel = 0; apply_reset();
    stim_q.delete(); exp_data.delete(); exp_user.delete(); exp_last.delete();
    gen_frames(0, 32, 32, 2); exp_frames(32, 32, 1024, 1);
    kth_beat = -1;
    run_stream(40, 10 * 32 + 5, 1024);
    count_diff(n, first);
    tests++; if (rst_mvalid !== 1'b0) begin fails++; $display("FAIL t5_mvalid_in_reset: got %b want 0", rst_mvalid); end
    tests++; if (got_data.size() != 225 || timed_out) begin fails++; $display("FAIL t5_words: got %0d want 225", got_data.size()); end
    tests++; if (n != 0) begin fails++; $display("FAIL t5_data: got %0d bad words (first %0d) want 0", n, first); end
    tests++; if (a_frame_cnt !== 16'd1) begin fails++; $display("FAIL t5_frame_cnt: got %0d want 1", a_frame_cnt); end
  endtask

  task automatic test_back_to_back();
    int n, first;
    sel = 0; apply_reset();
    stim_q.delete(); exp_data.delete(); exp_user.delete(); exp_last.delete();
    gen_frames(1, 32, 32, 2); exp_frames(32, 32, 0, 2);
    kth_beat = -1;
    run_stream(100, -1, 0);
    count_diff(n, first);
    tests++; if (n_stall != 0) begin fails++; $display("FAIL t6_input_stall: got %0d want 0", n_stall); end
    tests++; if (got_data.size() != 450 || timed_out) begin fails++; $display("FAIL t6_words: got %0d want 450", got_data.size()); end
    tests++; if (n != 0) begin fails++; $display("FAIL t6_data: got %0d bad words (first %0d) want 0", n, first); end
    if (got_data.size() == 450) begin
      tests++; if (got_last[224] !== 1'b1 || got_user[225] !== 1'b1)
        begin fails++; $display("FAIL t6_boundary: got last=%b user=%b want 1 1", got_last[224], got_user[225]); end
    end
    tests++; if (n_done != 2) begin fails++; $display("FAIL t6_frame_done: got %0d pulses want 2", n_done); end
    tests++; if (a_frame_cnt !== 16'd2) begin fails++; $display("FAIL t6_frame_cnt: got %0d want 2", a_frame_cnt); end
  endtask

  initial begin
    aresetn = 1'b0;
    kth_beat = -1;
    test_reset();
    test_full_frame();
    test_saturation();
    test_small_frame();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
